// File: rtl/sr_pkg.sv
// Shared types and widths for the frame sequencer.
package sr_pkg;
    localparam int PIXEL_WIDTH = 24;
    localparam int NBR_WIDTH   = 9 * PIXEL_WIDTH;
    localparam int COORD_WIDTH = 10;

    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, EMIT, DONE} state_t;
endpackage

// File: rtl/sr_coord_counter.sv
// Raster x/y counter; last flags the final pixel of the frame.
module sr_coord_counter
    import sr_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   advance,
    output logic [COORD_WIDTH-1:0] x,
    output logic [COORD_WIDTH-1:0] y,
    output logic                   last
);
    logic x_end, y_end;

    assign x_end = (x == COORD_WIDTH'(WIDTH - 1));
    assign y_end = (y == COORD_WIDTH'(HEIGHT - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sr_frame_sequencer.sv
// Walks a frame in raster order, fetching each 3x3 window, driving the SR datapath and streaming results.
// Optional WAIT watchdog enabled by defining SR_TIMEOUT_EN.
module sr_frame_sequencer
    import sr_pkg::*;
#(
    parameter int PIXEL_WIDTH    = 24,
    parameter int WIDTH          = 320,
    parameter int HEIGHT         = 240,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     win_req,
    output logic [COORD_WIDTH-1:0]   win_x,
    output logic [COORD_WIDTH-1:0]   win_y,
    input  logic                     win_valid,
    input  logic [9*PIXEL_WIDTH-1:0] win_data,
    output logic                     sr_start,
    output logic [COORD_WIDTH-1:0]   sr_x,
    output logic [COORD_WIDTH-1:0]   sr_y,
    output logic [9*PIXEL_WIDTH-1:0] sr_neighborhood,
    input  logic                     sr_pixel_done,
    input  logic [PIXEL_WIDTH-1:0]   sr_pixel_out,
    output logic                     out_valid,
    output logic [PIXEL_WIDTH-1:0]   out_data,
    input  logic                     out_ready,
    output logic                     err_timeout
);
    state_t                 state;
    logic [COORD_WIDTH-1:0] x, y;
    logic                   last;
    logic                   clear, advance;

    assign clear   = (state == IDLE) && frame_start;
    assign advance = (state == EMIT) && out_ready;
    assign win_x   = x;
    assign win_y   = y;

    sr_coord_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_coord (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (advance),
        .x       (x),
        .y       (y),
        .last    (last)
    );

`ifdef SR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign err_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            win_req         <= 1'b0;
            sr_start        <= 1'b0;
            sr_x            <= '0;
            sr_y            <= '0;
            sr_neighborhood <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
`ifdef SR_TIMEOUT_EN
            err_timeout     <= 1'b0;
            wait_cnt        <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            sr_start   <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    state   <= FETCH;
                    busy    <= 1'b1;
                    win_req <= 1'b1;
`ifdef SR_TIMEOUT_EN
                    err_timeout <= 1'b0;
`endif
                end
                FETCH: if (win_valid) begin
                    sr_neighborhood <= win_data;
                    sr_x            <= x;
                    sr_y            <= y;
                    win_req         <= 1'b0;
                    sr_start        <= 1'b1;
                    state           <= START;
                end
                START: begin
                    state <= WAIT;
`ifdef SR_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: if (sr_pixel_done) begin
                    out_data  <= sr_pixel_out;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
`ifdef SR_TIMEOUT_EN
                // A stuck datapath yields a zero pixel so the frame still completes.
                else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout <= 1'b1;
                    out_data    <= '0;
                    out_valid   <= 1'b1;
                    state       <= EMIT;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
`endif
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        win_req <= 1'b1;
                        state   <= FETCH;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_frame_sequencer.sv
// Scoreboarded bench for sr_frame_sequencer on a 4x2 frame with table-driven window/pixel data.
module tb_sr_frame_sequencer;
    localparam int PW = 24;
    localparam int NW = 9 * PW;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NP = W * H;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          busy, frame_done, win_req, sr_start, out_valid, err_timeout;
    logic [9:0]    win_x, win_y, sr_x, sr_y;
    logic          win_valid = 1'b0, sr_pixel_done = 1'b0, out_ready = 1'b0;
    logic [NW-1:0] win_data = '0, sr_neighborhood;
    logic [PW-1:0] sr_pixel_out = '0, out_data;

    sr_frame_sequencer #(.PIXEL_WIDTH(PW), .WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .win_req(win_req), .win_x(win_x), .win_y(win_y), .win_valid(win_valid), .win_data(win_data),
        .sr_start(sr_start), .sr_x(sr_x), .sr_y(sr_y), .sr_neighborhood(sr_neighborhood),
        .sr_pixel_done(sr_pixel_done), .sr_pixel_out(sr_pixel_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] win;
        logic [PW-1:0] pix;
    } vec_t;
    vec_t          tbl[NP];
    logic [PW-1:0] sbq[$];
    logic [PW-1:0] got[NP];

    int n_cmp = 0, n_err = 0, cyc = 0;
    int nstart = 0, nbeats = 0, stall_n = 0, wait_n = 0, busy_cyc = 0, done_cyc = -1;
    bit stall_en = 0, to_mode = 0, start_seen = 0, prev_busy = 0;
    logic in_wait;
    assign in_wait = busy && !win_req && !sr_start && !out_valid;

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] xy_of(input int k);
        logic [9:0] xx, yy;
        xx = 10'(k % W);
        yy = 10'(k / W);
        return {yy, xx};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Responders and monitor share one process so the drive/observe order is fixed.
    always @(negedge clk) begin
        if (!rst_n) begin
            win_valid     = 1'b0;
            sr_pixel_done = 1'b0;
            out_ready     = 1'b0;
            start_seen    = 1'b0;
            prev_busy     = 1'b0;
        end else begin
            win_valid     = win_req;
            win_data      = tbl[nstart % NP].win;
            sr_pixel_out  = (nstart > 0) ? tbl[(nstart - 1) % NP].pix : '0;
            sr_pixel_done = in_wait && !(to_mode && nstart == 1);
            if (in_wait && to_mode && nstart == 1) wait_n++;
            out_ready = 1'b1;
            if (stall_en && out_valid && nstart == 2 && stall_n < 5) begin
                out_ready = 1'b0;
                stall_n++;
                chk("stall_data", out_data, tbl[1].pix);
                chk("stall_coord", {win_y, win_x}, xy_of(1));
            end
            if (start_seen) chk("sr_start_width", sr_start, 1'b0);
            start_seen = sr_start;
            if (win_req && win_valid) chk("win_xy", {win_y, win_x}, xy_of(nstart));
            if (sr_start) begin
                chk("sr_nbr", sr_neighborhood, tbl[nstart % NP].win);
                chk("sr_xy", {sr_y, sr_x}, xy_of(nstart));
                sbq.push_back((to_mode && nstart == 0) ? '0 : tbl[nstart % NP].pix);
                nstart++;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_beat: got %0h expected none", out_data);
                end else begin
                    chk("out_data", out_data, sbq.pop_front());
                end
                if (nbeats < NP) got[nbeats] = out_data;
                nbeats++;
            end
            if (busy && !prev_busy) busy_cyc = cyc;
            prev_busy = busy;
            if (frame_done) begin
                done_cyc = cyc;
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic wait_nstart(input int n);
        int t = 0;
        while (nstart < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("wait_nstart_timeout", nstart >= n, 1'b1);
    endtask

    task automatic run_frame(input int exp_lat);
        int t = 0;
        nstart = 0; nbeats = 0; done_cyc = -1; sbq.delete();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        while (done_cyc < 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("frame_done_seen", done_cyc >= 0, 1'b1);
        chk("beats", nbeats, NP);
        chk("sb_empty", sbq.size(), 0);
        if (exp_lat > 0) chk("frame_latency", done_cyc - busy_cyc, exp_lat);
        for (int i = 0; i < NP; i++)
            chk("tbl_out", got[i], (to_mode && i == 0) ? '0 : tbl[i].pix);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {busy, frame_done, win_req, sr_start, out_valid, err_timeout}, '0);
        chk({tag, "_coord"}, {win_x, win_y, sr_x, sr_y}, '0);
        chk({tag, "_nbr"}, sr_neighborhood, '0);
        chk({tag, "_out"}, out_data, '0);
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            for (int j = 0; j < 9; j++) tbl[i].win[j*PW +: PW] = PW'($urandom);
            tbl[i].pix = PW'($urandom);
        end
        for (int b = 0; b < 27; b++) tbl[0].win[NW-1-8*b -: 8] = 8'(b + 1);
        tbl[0].pix = 24'hABCDEF;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait frame: raster order, data path and 32-cycle latency
        run_frame(32);

        // Output back-pressure at pixel (1,0)
        stall_en = 1; stall_n = 0;
        run_frame(0);
        stall_en = 0;
        chk("stall_cycles", stall_n, 5);

        // Ignored mid-frame start, then reset at pixel (2,1)
        nstart = 0; nbeats = 0; done_cyc = -1; sbq.delete();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        wait_nstart(3);
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        wait_nstart(7);
        @(negedge clk) rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        repeat (3) @(negedge clk);
        chk_zero("held_reset");
        sbq.delete(); nstart = 0; nbeats = 0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_reset", done_cyc, -1);
        chk("idle_after_reset", busy, 1'b0);
        run_frame(32);

`ifdef SR_TIMEOUT_EN
        to_mode = 1; wait_n = 0;
        run_frame(0);
        chk("timeout_wait_cycles", wait_n, TO);
        chk("err_sticky", err_timeout, 1'b1);
        to_mode = 0;
        run_frame(32);
        chk("err_cleared", err_timeout, 1'b0);
`else
        chk("err_tied_low", err_timeout, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
